// File: rtl/input_event_arbiter.sv
`default_nettype none
// ============================================================================
// input_event_arbiter: turns latched coin/buy/refund requests into one-hot,
// gap-spaced events. Priority is refund > buy > coin, round-robin within a group.
// Revision: 1.0
// ============================================================================
module input_event_arbiter #(
  parameter int GAP_CYCLES = 1,
  parameter int OVF_W      = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       moneyin_req,
  input  logic [3:0]       buy_req,
  input  logic             refund_req,
  input  logic             fsm_ready,
  output logic [3:0]       moneyin_evt,
  output logic [3:0]       buy_evt,
  output logic             refund_evt,
  output logic [8:0]       pending,
  output logic             busy,
  output logic [OVF_W-1:0] ovf_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int SUM_W = OVF_W + 4;
  localparam logic [OVF_W-1:0] OVF_MAX = '1;

  state_t           state;
  logic [GAP_W-1:0] gap_cnt;
  logic [1:0]       buy_ptr;
  logic [1:0]       moneyin_ptr;

  logic [8:0]       req_vec;
  logic [8:0]       grant_vec;
  logic [8:0]       drop_vec;
  logic [8:0]       pending_nxt;
  logic [3:0]       buy_pend;
  logic [3:0]       moneyin_pend;
  logic [1:0]       buy_idx;
  logic [1:0]       moneyin_idx;
  logic             buy_hit;
  logic             moneyin_hit;
  logic             grant_en;
  logic [3:0]       drop_num;
  logic [SUM_W-1:0] ovf_sum;
  logic [OVF_W-1:0] ovf_nxt;

  assign req_vec      = {refund_req, buy_req, moneyin_req};
  assign buy_pend     = pending[7:4];
  assign moneyin_pend = pending[3:0];

  // Scan from ptr+3 down to ptr so the candidate closest to the pointer wins.
  always_comb begin
    logic [1:0] cand;
    buy_hit     = 1'b0;
    buy_idx     = buy_ptr;
    moneyin_hit = 1'b0;
    moneyin_idx = moneyin_ptr;
    for (int k = 3; k >= 0; k--) begin
      cand = buy_ptr + 2'(k);
      if (buy_pend[cand]) begin
        buy_hit = 1'b1;
        buy_idx = cand;
      end
      cand = moneyin_ptr + 2'(k);
      if (moneyin_pend[cand]) begin
        moneyin_hit = 1'b1;
        moneyin_idx = cand;
      end
    end
  end

  always_comb begin
    grant_en  = (state == IDLE) && fsm_ready && (pending != 9'd0);
    grant_vec = '0;
    if (grant_en) begin
      if (pending[8]) begin
        grant_vec[8] = 1'b1;
      end else if (buy_hit) begin
        grant_vec[7:4] = 4'b0001 << buy_idx;
      end else if (moneyin_hit) begin
        grant_vec[3:0] = 4'b0001 << moneyin_idx;
      end
    end
  end

  // A request landing on an already-pending bit is a drop unless that bit is
  // being granted on the same edge, in which case it simply re-arms the bit.
  always_comb begin
    drop_vec    = req_vec & pending & ~grant_vec;
    pending_nxt = (pending & ~grant_vec) | req_vec;
    drop_num    = '0;
    for (int b = 0; b < 9; b++) begin
      drop_num = drop_num + 4'(drop_vec[b]);
    end
    ovf_sum = {4'b0000, ovf_cnt} + SUM_W'(drop_num);
    ovf_nxt = (ovf_sum > {4'b0000, OVF_MAX}) ? OVF_MAX : ovf_sum[OVF_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      gap_cnt     <= '0;
      buy_ptr     <= 2'd0;
      moneyin_ptr <= 2'd0;
      pending     <= '0;
      ovf_cnt     <= '0;
      busy        <= 1'b0;
      moneyin_evt <= '0;
      buy_evt     <= '0;
      refund_evt  <= 1'b0;
    end else begin
      pending <= pending_nxt;
      ovf_cnt <= ovf_nxt;
      case (state)
        IDLE: begin
          if (grant_en) begin
            refund_evt  <= grant_vec[8];
            buy_evt     <= grant_vec[7:4];
            moneyin_evt <= grant_vec[3:0];
            if (!pending[8]) begin
              if (buy_hit) begin
                buy_ptr <= buy_idx + 2'd1;
              end else begin
                moneyin_ptr <= moneyin_idx + 2'd1;
              end
            end
            busy  <= 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          refund_evt  <= 1'b0;
          buy_evt     <= '0;
          moneyin_evt <= '0;
          if (GAP_CYCLES == 0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gap_cnt <= GAP_W'(GAP_CYCLES);
            state   <= GAP;
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt - GAP_W'(1);
          if (gap_cnt == GAP_W'(1)) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/input_event_arbiter.md
Name: input_event_arbiter

Overview:
- Serialises coin, purchase and refund request pulses in the slow-clock domain into a stream of single, one-hot events for the vending machine FSM.
- Sits between the pulse generators / refund synchroniser and the vending machine. Its purpose is that the FSM never sees two events in one cycle and that events arriving while the FSM is busy are not lost.
- Latches each request, arbitrates with fixed group priority and round-robin within each group, enforces a programmable gap between issued events, and counts dropped duplicates.

Parameters:
- GAP_CYCLES, 1, number of idle cycles inserted after each issued event (0 allowed).
- OVF_W, 8, width of the saturating overflow counter.

Ports:
- clk  input  1  slow FSM-domain clock
- reset_n  input  1  asynchronous active-low reset
- moneyin_req  input  4  coin request pulses, bit i = coin i
- buy_req  input  4  purchase request pulses, bit i = item i
- refund_req  input  1  refund request pulse
- fsm_ready  input  1  FSM can accept an event this cycle
- moneyin_evt  output  4  one-cycle coin event to FSM
- buy_evt  output  4  one-cycle purchase event to FSM
- refund_evt  output  1  one-cycle refund event to FSM
- pending  output  9  latched requests {refund, buy[3:0], moneyin[3:0]}
- busy  output  1  high in ISSUE or GAP state
- ovf_cnt  output  OVF_W  saturating count of dropped requests

Behaviour:
- Reset (asynchronous, any state): all evt outputs = 0, pending = 0, busy = 0, ovf_cnt = 0, both round-robin pointers = 0, gap counter = 0, state = IDLE.
- Latching: on each clk edge, for each request bit i with req high, pending[i] is set.
  - If pending[i] is already 1 and is not being granted at that edge, the request is dropped and ovf_cnt increments; it saturates at 2^OVF_W-1.
  - Several drops on the same edge count as several increments, still saturating.
  - If a request arrives on the same edge that its pending bit is granted, the bit stays 1 (the new request is kept) and no overflow is counted.
- States:
  - IDLE: if pending != 0 and fsm_ready = 1, choose the winner, clear its pending bit, drive its evt bit for the next cycle, go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: exactly one evt bit is high for this single cycle. busy = 1. If GAP_CYCLES = 0 go to IDLE, else load the gap counter with GAP_CYCLES and go to GAP.
  - GAP: busy = 1, all evt = 0, decrement the gap counter; go to IDLE when it reaches 1.
- Priority: refund > any buy > any moneyin.
  - Within buy, round-robin starting at buy_ptr; after a buy grant at index i, buy_ptr becomes (i+1) mod 4.
  - moneyin uses the same scheme with its own pointer, moneyin_ptr.
  - The pointer of a group that is not granted does not change.
- fsm_ready is sampled only in IDLE; deasserting it during ISSUE or GAP has no effect on the event already issued.
- Latency:
  - req high in cycle n -> pending high from cycle n+1 -> evt high in cycle n+2, when the arbiter is idle and ready = 1.
  - Back-to-back issue spacing is 2 + GAP_CYCLES cycles.
- Invariants: at most one of the 9 evt bits is high in any cycle; evt is never high for 2 consecutive cycles.
- Starvation: a moneyin request can wait indefinitely while buy or refund requests keep arriving. This is accepted, because button rates are far below the clock rate.

Test Plan:
- Reset with all requests pending -> pending = 0, evt = 0, ovf_cnt = 0 immediately, with no clock needed; after release, no event is issued.
- Single moneyin_req = 4'b0100 in cycle 0, fsm_ready = 1, GAP = 1 -> pending = 9'h004 in cycle 1; moneyin_evt = 4'b0100 in cycle 2 only; busy high in cycles 2–3.
- One-cycle pulse of refund_req = 1, buy_req = 4'b0011, moneyin_req = 4'b0001 together, GAP = 1 -> events in order refund, buy[0], buy[1], moneyin[0], one issued every 3 cycles; buy_ptr ends at 2.
- fsm_ready = 0 for 10 cycles with buy[2] pending -> no event issued; event issued 1 cycle after ready rises.
- buy_req[3] pulsed on 300 non-granting cycles while fsm_ready = 0 -> ovf_cnt saturates at 255; pending[7] = 1.
- buy_req[1] pulsed on the exact edge its pending bit is granted -> buy_evt[1] issued twice; ovf_cnt unchanged.
